// File: rtl/uart_rx_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and legal parameter bounds for the parametrised
//               UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Parity mode selector (matches the integer PARITY parameter encoding)
    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } uart_parity_e;

    // Receiver FSM states
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_START      = 3'd1,
        S_DATA       = 3'd2,
        S_PARITY     = 3'd3,
        S_STOP       = 3'd4,
        S_BREAK_WAIT = 3'd5
    } uart_rx_state_e;

    // Legal parameter bounds
    localparam int c_data_bits_min = 5;
    localparam int c_data_bits_max = 9;
    localparam int c_os_rate_min   = 8;
    localparam int c_os_rate_max   = 32;
    localparam int c_stop_bits_min = 1;
    localparam int c_stop_bits_max = 2;

endpackage
`default_nettype wire

// File: rtl/uart_rx_param_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_param_if
// Description : Output word handshake and status of the UART receiver.
//               master = receiver side, slave = downstream consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, overrun, busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, overrun, busy,
        output rx_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchroniser for the asynchronous rx line. Resets to
//               the idle (high) line level so reset never looks like a start.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  wire  clk,
    input  wire  rst,
    input  wire  i_rx,
    output logic o_rxs
);
    logic r_meta;
    logic r_sync;

    // Double-register the raw line; both stages idle high in reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
        end
    end

    assign o_rxs = r_sync;
endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_param
// Description : Parametrised oversampling UART receiver. Mid-bit sampling,
//               LSB-first data, optional parity, 1 or 2 checked stop bits,
//               valid/ready output register with overrun reporting and
//               line-break lockout.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int OS_RATE   = 16,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  wire             clk,
    input  wire             rst,
    input  wire             os_tick,
    input  wire             rx,
    uart_rx_param_if.master rx_if
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------
    if (DATA_BITS < c_data_bits_min || DATA_BITS > c_data_bits_max) begin : g_bad_data_bits
        $error("uart_rx_param: DATA_BITS out of range");
    end
    if (OS_RATE < c_os_rate_min || OS_RATE > c_os_rate_max || (OS_RATE % 2) != 0) begin : g_bad_os_rate
        $error("uart_rx_param: OS_RATE must be even and in range");
    end
    if (PARITY < int'(PAR_NONE) || PARITY > int'(PAR_ODD)) begin : g_bad_parity
        $error("uart_rx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < c_stop_bits_min || STOP_BITS > c_stop_bits_max) begin : g_bad_stop_bits
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end

    localparam int                 c_tick_w    = $clog2(OS_RATE);
    localparam int                 c_bit_w     = $clog2(DATA_BITS);
    localparam logic [c_tick_w-1:0] c_tick_half = c_tick_w'(OS_RATE / 2 - 1);
    localparam logic [c_tick_w-1:0] c_tick_full = c_tick_w'(OS_RATE - 1);
    localparam logic [c_tick_w-1:0] c_tick_one  = c_tick_w'(1);
    localparam logic [c_bit_w-1:0]  c_data_last = c_bit_w'(DATA_BITS - 1);
    localparam logic [c_bit_w-1:0]  c_stop_last = c_bit_w'(STOP_BITS - 1);
    localparam logic [c_bit_w-1:0]  c_bit_one   = c_bit_w'(1);
    localparam bit                 c_par_en    = (PARITY != int'(PAR_NONE));
    localparam bit                 c_par_odd   = (PARITY == int'(PAR_ODD));

    uart_rx_state_e        r_state;
    uart_rx_state_e        w_next_state;
    logic [c_tick_w-1:0]   r_tick_cnt;
    logic [c_tick_w-1:0]   w_tick_tgt;
    logic [c_bit_w-1:0]    r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_par_acc;
    logic                  r_frm_acc;
    logic [DATA_BITS-1:0]  r_data;
    logic                  r_valid;
    logic                  r_par_err;
    logic                  r_frm_err;
    logic                  r_overrun;
    logic                  w_rxs;
    logic                  w_tick_hit;
    logic                  w_frm_now;
    logic                  w_start_ok;
    logic                  w_data_smp;
    logic                  w_par_smp;
    logic                  w_stop_smp;
    logic                  w_complete;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .i_rx  (rx),
        .o_rxs (w_rxs)
    );

    // The start bit is verified half a bit in; every later sample is a full bit on
    assign w_tick_tgt = (r_state == S_START) ? c_tick_half : c_tick_full;
    assign w_tick_hit = os_tick && (r_tick_cnt == w_tick_tgt);
    // Frame error including the stop sample being taken this cycle
    assign w_frm_now  = r_frm_acc | ~w_rxs;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and per-cycle sampling strobes
    always_comb begin
        w_next_state = r_state;
        w_start_ok   = 1'b0;
        w_data_smp   = 1'b0;
        w_par_smp    = 1'b0;
        w_stop_smp   = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (os_tick && !w_rxs) begin
                    w_next_state = S_START;
                end
            end
            S_START: begin
                if (w_tick_hit) begin
                    w_start_ok   = !w_rxs;
                    w_next_state = w_rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick_hit) begin
                    w_data_smp = 1'b1;
                    if (r_bit_cnt == c_data_last) begin
                        w_next_state = c_par_en ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (w_tick_hit) begin
                    w_par_smp    = 1'b1;
                    w_next_state = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick_hit) begin
                    w_stop_smp = 1'b1;
                    if (r_bit_cnt == c_stop_last) begin
                        w_complete = 1'b1;
                        // An all-zero frame with a bad stop is a line break:
                        // hold off until the line returns high
                        w_next_state = (w_frm_now && (r_shift == '0)) ? S_BREAK_WAIT : S_IDLE;
                    end
                end
            end
            S_BREAK_WAIT: begin
                if (os_tick && w_rxs) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Oversampling tick counter: restarts at each sample point and while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (os_tick) begin
            if (r_state == S_IDLE || r_state == S_BREAK_WAIT || w_tick_hit) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + c_tick_one;
            end
        end
    end

    // Bit counter (data bits, then reused for stop bits), shift register and
    // per-frame error accumulators
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_acc <= 1'b0;
            r_frm_acc <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_bit_cnt <= '0;
                r_par_acc <= 1'b0;
                r_frm_acc <= 1'b0;
            end
            if (w_data_smp) begin
                r_shift   <= {w_rxs, r_shift[DATA_BITS-1:1]};
                r_bit_cnt <= (r_bit_cnt == c_data_last) ? '0 : (r_bit_cnt + c_bit_one);
            end
            if (w_par_smp) begin
                r_par_acc <= (^r_shift) ^ w_rxs ^ c_par_odd;
            end
            if (w_stop_smp) begin
                r_bit_cnt <= r_bit_cnt + c_bit_one;
                if (!w_rxs) begin
                    r_frm_acc <= 1'b1;
                end
            end
        end
    end

    // Output register: load on completion if empty or draining, else drop and flag overrun
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_complete && (!r_valid || rx_if.rx_ready)) begin
                r_data    <= r_shift;
                r_par_err <= r_par_acc;
                r_frm_err <= w_frm_now;
                r_valid   <= 1'b1;
            end else begin
                if (w_complete) begin
                    r_overrun <= 1'b1;
                end
                if (r_valid && rx_if.rx_ready) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign rx_if.rx_data    = r_data;
    assign rx_if.rx_valid   = r_valid;
    assign rx_if.parity_err = r_par_err;
    assign rx_if.frame_err  = r_frm_err;
    assign rx_if.overrun    = r_overrun;
    assign rx_if.busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire
